ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16, sets the width of the requester and phy address buses.
REQ-002 Parameter DATA_W, default 16, sets the width of the write and read data buses.
REQ-003 Parameter MAX_BURST, default 8, sets the maximum number of consecutive grants to one owner while the other requester waits (range 1..15).
REQ-004 The block SHALL have one clock and a synchronous, active-high reset, with these ports:
 clk  in  1  sole clock; all state updates on posedge.
 rst  in  1  synchronous active-high reset.
 req0 / req1  in  1  access request from requester 0 (CPU) / 1 (loader or DMA).
 op0 / op1  in  1  access type: 1 = write, 0 = read.
 addr0 / addr1  in  ADDR_W  access address.
 wdata0 / wdata1  in  DATA_W  write data.
 lock0 / lock1  in  1  owner keeps the bus past MAX_BURST while high.
 gnt0 / gnt1  out  1  access issued this cycle (combinational).
 rvalid0 / rvalid1  out  1  read data valid (registered).
 rdata0 / rdata1  out  DATA_W  read data; valid when rvalid is high.
 phy_ram_addr  out  ADDR_W  RAM address.
 phy_ram_write  out  DATA_W  RAM write data.
 phy_ram_op  out  1  RAM write enable.
 phy_ram_read  in  DATA_W  RAM read data, valid one cycle after the address is presented.

Function
REQ-005 FSM states SHALL be IDLE, OWN0 and OWN1; the state register SHALL hold the previous cycle's winner, or IDLE if there was no winner.
REQ-006 The winner SHALL be computed combinationally each cycle as follows:
 - only one req high: that requester wins;
 - both high, state OWNk, and (burst_cnt < MAX_BURST or lockk): k wins;
 - otherwise: the requester other than last_win wins.
REQ-007 At most one gnt SHALL be high per cycle, and gntk SHALL be high only if reqk is high.
REQ-008 A granted access SHALL drive phy_ram_addr, phy_ram_op and phy_ram_write from the winner's addr, op and wdata in the same cycle.
REQ-009 With no winner, the phy outputs SHALL be phy_ram_addr = 0, phy_ram_op = 0 and phy_ram_write = 0.
REQ-010 A requester SHALL hold req, op, addr and wdata stable until it sees gnt; it may drop req before grant, and that request is then abandoned with no side effect.
REQ-011 A granted read SHALL raise rvalidk for exactly one cycle, on the cycle after the grant, with rdatak equal to phy_ram_read in that cycle.
REQ-012 Read data handling SHALL otherwise follow these rules:
 - writes produce no rvalid;
 - rdatak holds its last value when rvalidk is low;
 - back-to-back grants give back-to-back rvalid with no bubble.
REQ-013 burst_cnt (4 bits) SHALL follow these rules:
 - set to 1 when the winner differs from the state's owner or the state is IDLE;
 - increment, saturating at 15, when the same owner wins again;
 - clear to 0 when there is no winner.
REQ-014 last_win SHALL update to the winner on every granted cycle and hold otherwise.
REQ-015 An owner switch SHALL take zero idle cycles: a grant to the other requester occurs in the cycle the limit is hit.
REQ-016 When lock is dropped with burst_cnt >= MAX_BURST and the other requester is requesting, the bus SHALL switch in that same cycle.
REQ-017 When both requesters first request simultaneously from IDLE, the winner SHALL be the one other than last_win.

Reset
REQ-018 Reset SHALL apply the following values:
 - state = IDLE, burst_cnt = 0, last_win = 1 (so requester 0 wins the first tie);
 - rvalid0 = rvalid1 = 0, rdata0 = rdata1 = 0;
 - phy outputs take their no-winner values.
REQ-019 Reset asserted in the cycle after a read grant SHALL suppress that rvalid, and gnt SHALL be forced low while rst is high.

Structure
REQ-020 Package mem_arb_pkg SHALL hold the state enum (IDLE, OWN0, OWN1) and the constants OP_READ = 0 and OP_WRITE = 1.
REQ-021 The block SHALL have no sub-module; it SHALL be a flat FSM, counters and output mux in one module.

Verification
REQ-022 Scenario 1: req0 read at addr 0x0010 with RAM returning 0xBEEF -> gnt0 in cycle 0, and rvalid0 = 1 with rdata0 = 0xBEEF in cycle 1; gnt1 stays 0 throughout.
REQ-023 Scenario 2: req0 and req1 held high from reset, MAX_BURST = 8 -> gnt0 for cycles 0..7, gnt1 for 8..15, gnt0 again at 16, with no idle cycle.
REQ-024 Scenario 3: same as scenario 2 with lock0 high until cycle 11 -> gnt0 for cycles 0..11 and gnt1 from cycle 12.
REQ-025 Scenario 4: req1 write at addr 0x0100 with data 0x1234 -> phy_ram_op = 1, phy_ram_addr = 0x0100 and phy_ram_write = 0x1234 for one cycle, and no rvalid1.
REQ-026 Scenario 5: rst asserted one cycle after a read grant to requester 1 -> rvalid1 stays 0, and the next simultaneous request goes to requester 0.
REQ-027 Scenario 6: req0 dropped before grant while requester 1 owns the bus -> no gnt0 and no phy access to addr0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

endpackage

// File: rtl/ram_arbiter.sv
// Two-requester single-port RAM arbiter: burst-limited ownership with lock
// override, zero-bubble owner switches and one-cycle read return.
module ram_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              op0,
  input  logic              op1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              lock0,
  input  logic              lock1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] phy_ram_addr,
  output logic [DATA_W-1:0] phy_ram_write,
  output logic              phy_ram_op,
  input  logic [DATA_W-1:0] phy_ram_read
);

  localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);

  arb_state_t        state;
  logic [3:0]        burst_cnt;
  logic              last_win;
  logic              win_valid;
  logic              win_sel;
  logic              rvalid0_q;
  logic              rvalid1_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;

  // The current owner keeps the bus on a tie until its burst budget runs out,
  // unless it holds lock; otherwise the tie alternates away from last_win.
  always_comb begin
    win_valid = 1'b0;
    win_sel   = 1'b0;
    if (!rst) begin
      if (req0 && !req1) begin
        win_valid = 1'b1;
        win_sel   = 1'b0;
      end else if (req1 && !req0) begin
        win_valid = 1'b1;
        win_sel   = 1'b1;
      end else if (req0 && req1) begin
        win_valid = 1'b1;
        if (state == OWN0 && (burst_cnt < BURST_LIMIT || lock0))
          win_sel = 1'b0;
        else if (state == OWN1 && (burst_cnt < BURST_LIMIT || lock1))
          win_sel = 1'b1;
        else
          win_sel = ~last_win;
      end
    end
  end

  assign gnt0 = win_valid && !win_sel;
  assign gnt1 = win_valid && win_sel;

  always_comb begin
    phy_ram_addr  = '0;
    phy_ram_write = '0;
    phy_ram_op    = OP_READ;
    if (win_valid) begin
      phy_ram_addr  = win_sel ? addr1  : addr0;
      phy_ram_write = win_sel ? wdata1 : wdata0;
      phy_ram_op    = win_sel ? op1    : op0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      burst_cnt <= 4'd0;
      last_win  <= 1'b1;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      rvalid0_q <= gnt0 && (op0 == OP_READ);
      rvalid1_q <= gnt1 && (op1 == OP_READ);
      if (rvalid0_q) rdata0_q <= phy_ram_read;
      if (rvalid1_q) rdata1_q <= phy_ram_read;
      if (!win_valid) begin
        state     <= IDLE;
        burst_cnt <= 4'd0;
      end else begin
        last_win <= win_sel;
        state    <= win_sel ? OWN1 : OWN0;
        if (state == IDLE || ((state == OWN1) != win_sel))
          burst_cnt <= 4'd1;
        else if (burst_cnt != 4'hF)
          burst_cnt <= burst_cnt + 4'd1;
      end
    end
  end

  // Read data is live from the RAM in the return cycle and held afterwards.
  assign rvalid0 = rvalid0_q && !rst;
  assign rvalid1 = rvalid1_q && !rst;
  assign rdata0  = rvalid0 ? phy_ram_read : rdata0_q;
  assign rdata1  = rvalid1 ? phy_ram_read : rdata1_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios plus a randomized
// run against a transaction-level arbitration model.
module tb_ram_arbiter;

  localparam int MAXB = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, op0, op1, lock0, lock1;
  logic [15:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, phy_ram_op;
  logic [15:0] rdata0, rdata1, phy_ram_addr, phy_ram_write, phy_ram_read;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: who won last cycle, how long their unbroken run is,
  // who won most recently at all, and per-port read return tracking.
  int          m_owner;
  int          m_run;
  int          m_last;
  bit          m_rvp [2];
  logic [15:0] m_hold [2];

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_BURST(MAXB)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .lock0(lock0), .lock1(lock1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .phy_ram_addr(phy_ram_addr), .phy_ram_write(phy_ram_write),
    .phy_ram_op(phy_ram_op), .phy_ram_read(phy_ram_read)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req0 = 0; req1 = 0; op0 = 0; op1 = 0; lock0 = 0; lock1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0; phy_ram_read = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    next_cycle();
    rst = 0;
  endtask

  function automatic int model_winner();
    if (rst) return -1;
    if (req0 && !req1) return 0;
    if (req1 && !req0) return 1;
    if (!req0 && !req1) return -1;
    if (m_owner == 0 && (m_run < MAXB || lock0)) return 0;
    if (m_owner == 1 && (m_run < MAXB || lock1)) return 1;
    return 1 - m_last;
  endfunction

  function automatic void model_update(int win);
    if (rst) begin
      m_owner = -1; m_run = 0; m_last = 1;
      m_rvp[0] = 0; m_rvp[1] = 0; m_hold[0] = '0; m_hold[1] = '0;
    end else begin
      for (int k = 0; k < 2; k++) if (m_rvp[k]) m_hold[k] = phy_ram_read;
      m_rvp[0] = (win == 0) && (op0 == 1'b0);
      m_rvp[1] = (win == 1) && (op1 == 1'b0);
      if (win < 0) begin
        m_owner = -1; m_run = 0;
      end else begin
        m_run   = (win == m_owner) ? m_run + 1 : 1;
        m_owner = win;
        m_last  = win;
      end
    end
  endfunction

  task automatic test_reset();
    clear_inputs();
    rst = 1; req0 = 1; req1 = 1; addr0 = 16'h1357; addr1 = 16'h2468;
    #3;
    n_checks++; if (gnt0 !== 1'b0) begin n_errors++; $display("[TB] FAIL rst_gnt0: got %b expected 0", gnt0); end
    n_checks++; if (gnt1 !== 1'b0) begin n_errors++; $display("[TB] FAIL rst_gnt1: got %b expected 0", gnt1); end
    n_checks++; if (phy_ram_addr !== 16'h0) begin n_errors++; $display("[TB] FAIL rst_phy_addr: got %h expected 0000", phy_ram_addr); end
    next_cycle();
    #3;
    n_checks++; if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin n_errors++; $display("[TB] FAIL rst_rvalid: got %b%b expected 00", rvalid0, rvalid1); end
    n_checks++; if (rdata0 !== 16'h0 || rdata1 !== 16'h0) begin n_errors++; $display("[TB] FAIL rst_rdata: got %h/%h expected 0000/0000", rdata0, rdata1); end
    n_checks++; if (phy_ram_op !== 1'b0 || phy_ram_write !== 16'h0) begin n_errors++; $display("[TB] FAIL rst_phy: got op %b wr %h expected 0/0000", phy_ram_op, phy_ram_write); end
    next_cycle();
    rst = 0;
  endtask

  task automatic test_single_read();
    do_reset();
    req0 = 1; op0 = 0; addr0 = 16'h0010;
    #3;
    n_checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin n_errors++; $display("[TB] FAIL s1_gnt_c0: got %b%b expected 10", gnt0, gnt1); end
    n_checks++; if (phy_ram_addr !== 16'h0010 || phy_ram_op !== 1'b0) begin n_errors++; $display("[TB] FAIL s1_phy: got %h op %b expected 0010 op 0", phy_ram_addr, phy_ram_op); end
    next_cycle();
    req0 = 0; phy_ram_read = 16'hBEEF;
    #3;
    n_checks++; if (rvalid0 !== 1'b1 || rdata0 !== 16'hBEEF) begin n_errors++; $display("[TB] FAIL s1_rdata: got v%b %h expected v1 beef", rvalid0, rdata0); end
    n_checks++; if (gnt1 !== 1'b0 || rvalid1 !== 1'b0) begin n_errors++; $display("[TB] FAIL s1_port1: got gnt1 %b rvalid1 %b expected 0 0", gnt1, rvalid1); end
    next_cycle();
    phy_ram_read = 16'h5555;
    #3;
    n_checks++; if (rvalid0 !== 1'b0 || rdata0 !== 16'hBEEF) begin n_errors++; $display("[TB] FAIL s1_hold: got v%b %h expected v0 beef", rvalid0, rdata0); end
  endtask

  task automatic test_burst_rotation(input bit with_lock);
    do_reset();
    req0 = 1; req1 = 1;
    for (int c = 0; c < 20; c++) begin
      bit e0, e1, prev0;
      lock0 = with_lock && (c <= 11);
      if (with_lock) begin
        e0 = (c < 12); e1 = (c >= 12);
        prev0 = (c >= 1) && (c - 1 < 12);
      end else begin
        e0 = (c < 8) || (c >= 16); e1 = !e0;
        prev0 = (c >= 1) && ((c - 1 < 8) || (c - 1 >= 16));
      end
      #3;
      n_checks++; if (gnt0 !== e0 || gnt1 !== e1) begin n_errors++; $display("[TB] FAIL burst_lock%0d_c%0d: got %b%b expected %b%b", with_lock, c, gnt0, gnt1, e0, e1); end
      if (c >= 1) begin
        n_checks++; if (rvalid0 !== prev0 || rvalid1 !== !prev0) begin n_errors++; $display("[TB] FAIL burst_rvalid%0d_c%0d: got %b%b expected %b%b", with_lock, c, rvalid0, rvalid1, prev0, !prev0); end
      end
      next_cycle();
    end
    lock0 = 0;
  endtask

  task automatic test_write();
    do_reset();
    req1 = 1; op1 = 1; addr1 = 16'h0100; wdata1 = 16'h1234;
    #3;
    n_checks++; if (phy_ram_op !== 1'b1 || phy_ram_addr !== 16'h0100 || phy_ram_write !== 16'h1234) begin n_errors++; $display("[TB] FAIL s4_phy: got op %b %h %h expected 1 0100 1234", phy_ram_op, phy_ram_addr, phy_ram_write); end
    n_checks++; if (gnt1 !== 1'b1) begin n_errors++; $display("[TB] FAIL s4_gnt1: got %b expected 1", gnt1); end
    next_cycle();
    req1 = 0;
    #3;
    n_checks++; if (rvalid1 !== 1'b0) begin n_errors++; $display("[TB] FAIL s4_rvalid1: got %b expected 0", rvalid1); end
    n_checks++; if (phy_ram_op !== 1'b0 || phy_ram_addr !== 16'h0) begin n_errors++; $display("[TB] FAIL s4_idle_phy: got op %b %h expected 0 0000", phy_ram_op, phy_ram_addr); end
  endtask

  task automatic test_reset_after_read();
    do_reset();
    req1 = 1; op1 = 0; addr1 = 16'h0042;
    #3;
    n_checks++; if (gnt1 !== 1'b1) begin n_errors++; $display("[TB] FAIL s5_gnt1: got %b expected 1", gnt1); end
    next_cycle();
    req1 = 0; rst = 1; phy_ram_read = 16'hCAFE;
    #3;
    n_checks++; if (rvalid1 !== 1'b0) begin n_errors++; $display("[TB] FAIL s5_rvalid1: got %b expected 0", rvalid1); end
    next_cycle();
    rst = 0; req0 = 1; req1 = 1;
    #3;
    n_checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin n_errors++; $display("[TB] FAIL s5_tie: got %b%b expected 10", gnt0, gnt1); end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_abandon();
    do_reset();
    req1 = 1; op1 = 0; addr1 = 16'h0200;
    next_cycle();
    req0 = 1; op0 = 1; addr0 = 16'hAAAA; wdata0 = 16'h7777;
    #3;
    n_checks++; if (gnt0 !== 1'b0 || phy_ram_addr !== 16'h0200) begin n_errors++; $display("[TB] FAIL s6_wait: got gnt0 %b addr %h expected 0 0200", gnt0, phy_ram_addr); end
    next_cycle();
    req0 = 0;
    #3;
    n_checks++; if (gnt0 !== 1'b0 || phy_ram_addr === 16'hAAAA) begin n_errors++; $display("[TB] FAIL s6_drop: got gnt0 %b addr %h expected 0 not aaaa", gnt0, phy_ram_addr); end
    next_cycle();
    req1 = 0;
    #3;
    n_checks++; if (gnt0 !== 1'b0 || phy_ram_op !== 1'b0 || phy_ram_addr !== 16'h0) begin n_errors++; $display("[TB] FAIL s6_after: got gnt0 %b op %b addr %h expected 0 0 0000", gnt0, phy_ram_op, phy_ram_addr); end
  endtask

  task automatic test_random();
    bit          r_req [2];
    bit          r_op [2];
    logic [15:0] r_addr [2];
    logic [15:0] r_wdata [2];
    int          prev_win;
    do_reset();
    m_owner = -1; m_run = 0; m_last = 1;
    m_rvp[0] = 0; m_rvp[1] = 0; m_hold[0] = '0; m_hold[1] = '0;
    for (int k = 0; k < 2; k++) begin r_req[k] = 0; r_op[k] = 0; r_addr[k] = 0; r_wdata[k] = 0; end
    prev_win = -1;
    for (int c = 0; c < 600; c++) begin
      int          win;
      bit          ev0, ev1;
      logic [15:0] ea, ew, ed0, ed1;
      bit          eo;
      // Pending requests stay stable (or get abandoned) until granted.
      for (int k = 0; k < 2; k++) begin
        if (r_req[k] && prev_win != k) begin
          if ($urandom_range(0, 7) == 0) r_req[k] = 0;
        end else begin
          r_req[k]   = ($urandom_range(0, 3) != 0);
          r_op[k]    = $urandom_range(0, 1);
          r_addr[k]  = 16'($urandom);
          r_wdata[k] = 16'($urandom);
        end
      end
      req0 = r_req[0]; op0 = r_op[0]; addr0 = r_addr[0]; wdata0 = r_wdata[0];
      req1 = r_req[1]; op1 = r_op[1]; addr1 = r_addr[1]; wdata1 = r_wdata[1];
      lock0 = ($urandom_range(0, 3) == 0);
      lock1 = ($urandom_range(0, 3) == 0);
      phy_ram_read = 16'($urandom);
      rst = ($urandom_range(0, 79) == 0);
      #3;
      win = model_winner();
      ea  = (win == 0) ? addr0  : (win == 1) ? addr1  : 16'h0;
      ew  = (win == 0) ? wdata0 : (win == 1) ? wdata1 : 16'h0;
      eo  = (win == 0) ? op0    : (win == 1) ? op1    : 1'b0;
      ev0 = m_rvp[0] && !rst;
      ev1 = m_rvp[1] && !rst;
      ed0 = ev0 ? phy_ram_read : m_hold[0];
      ed1 = ev1 ? phy_ram_read : m_hold[1];
      n_checks++; if (gnt0 !== (win == 0) || gnt1 !== (win == 1)) begin n_errors++; $display("[TB] FAIL rnd_gnt_c%0d: got %b%b expected winner %0d", c, gnt0, gnt1, win); end
      n_checks++; if (phy_ram_addr !== ea || phy_ram_write !== ew || phy_ram_op !== eo) begin n_errors++; $display("[TB] FAIL rnd_phy_c%0d: got %h %h %b expected %h %h %b", c, phy_ram_addr, phy_ram_write, phy_ram_op, ea, ew, eo); end
      n_checks++; if (rvalid0 !== ev0 || rvalid1 !== ev1) begin n_errors++; $display("[TB] FAIL rnd_rvalid_c%0d: got %b%b expected %b%b", c, rvalid0, rvalid1, ev0, ev1); end
      n_checks++; if (rdata0 !== ed0 || rdata1 !== ed1) begin n_errors++; $display("[TB] FAIL rnd_rdata_c%0d: got %h/%h expected %h/%h", c, rdata0, rdata1, ed0, ed1); end
      model_update(win);
      prev_win = win;
      next_cycle();
    end
    rst = 0;
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    test_reset();
    test_single_read();
    test_burst_rotation(1'b0);
    test_burst_rotation(1'b1);
    test_write();
    test_reset_after_read();
    test_abandon();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
